// File: rtl/i2c_lcd_if.sv
// Parallel-port side of the I2C LCD backpack target: the PCF8574-style
// input/output byte plus status. The block itself uses the slave modport.
interface i2c_lcd_if;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       port_valid;
  logic       busy;

  modport slave  (input  port_in, output port_out, output port_valid, output busy);
  modport master (output port_in, input  port_out, input  port_valid, input  busy);
endinterface

// File: rtl/i2c_lcd_target.sv
// I2C target emulating a PCF8574 LCD backpack: oversamples scl/sda on clk,
// latches written bytes onto port_out and returns port_in on reads.
module i2c_lcd_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h27,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  i2c_lcd_if.slave   pio
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             port_out_q, port_out_d;
  logic                   rw_q, rw_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   port_valid_q, port_valid_d;
  logic                   busy_q, busy_d;

  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic       addr_match, last_bit;

  assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
  assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];

  // Bus conditions only count while scl is stable high across both samples.
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte    = {shift_q[6:0], sda_s};
  assign addr_match = (shift_q[6:0] == I2C_ADDR);
  assign last_bit   = (bit_cnt_q == 4'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      port_out_q   <= 8'hFF;
      rw_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      port_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_s;
      sda_prev_q   <= sda_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      port_out_q   <= port_out_d;
      rw_q         <= rw_d;
      sda_oe_q     <= sda_oe_d;
      port_valid_q <= port_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     state_d = IDLE;
        ADDR:     if (scl_rise && last_bit) state_d = addr_match ? ADDR_ACK : IDLE;
        ADDR_ACK: if (scl_fall && bit_cnt_q == 4'd9) state_d = rw_q ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_rise && last_bit) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && bit_cnt_q == 4'd9) state_d = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt_q == 4'd8) state_d = RD_ACK;
        RD_ACK: begin
          if (scl_rise && sda_s)                       state_d = IDLE;
          else if (scl_fall && bit_cnt_q == 4'd9)      state_d = RD_DATA;
        end
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    port_out_d   = port_out_q;
    rw_d         = rw_q;
    sda_oe_d     = sda_oe_q;
    port_valid_d = 1'b0;
    if (start_det) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) rw_d = sda_s;
          end
        end
        // Count 8 marks "ACK not yet driven", 9 marks "ACK bit in flight".
        ADDR_ACK, WR_ACK: begin
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              shift_d  = pio.port_in;
              sda_oe_d = ~pio.port_in[7];
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (last_bit) begin
              port_out_d   = rx_byte;
              port_valid_d = 1'b1;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = sda_s ? 4'd0 : 4'd9;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            shift_d   = pio.port_in;
            sda_oe_d  = ~pio.port_in[7];
            bit_cnt_d = '0;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end

    busy_d = busy_q;
    if (state_d == IDLE)          busy_d = 1'b0;
    else if (state_d == ADDR_ACK) busy_d = 1'b1;
  end

  assign sda            = sda_oe_q ? 1'b0 : 1'bz;
  assign pio.port_out   = port_out_q;
  assign pio.port_valid = port_valid_q;
  assign pio.busy       = busy_q;

endmodule
